// File: rtl/lcd_frame_reader.sv
// LCD scan-out timing plus frame-buffer unpacking into 10-bit RGB; outputs lag the counters by 2 clocks.
// No backpressure: reads are strobed blindly while active, an empty FIFO yields black pixels and a sticky underflow.
module lcd_frame_reader #(
    parameter int H_SYNC   = 30,
    parameter int H_BP     = 46,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 23,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 7
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic [15:0] iRd1_data,
    input  logic [15:0] iRd2_data,
    input  logic        iRd_empty,
    input  logic        iClrUnderflow,
    output logic        oRd_req,
    output logic [9:0]  oLCD_R,
    output logic [9:0]  oLCD_G,
    output logic [9:0]  oLCD_B,
    output logic        oLCD_HS,
    output logic        oLCD_VS,
    output logic        oLCD_DE,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic        oFrameStart,
    output logic        oUnderflow
);

    localparam logic [15:0] H_LAST  = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [15:0] V_LAST  = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [15:0] H_SYNC_E = 16'(H_SYNC);
    localparam logic [15:0] V_SYNC_E = 16'(V_SYNC);
    localparam logic [15:0] H_ACT_S = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_ACT_E = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] V_ACT_S = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_E = 16'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t      state, state_nxt;
    logic [15:0] hc, vc;
    logic        frame_wrap, active;

    logic        s1_req, s1_uf, s1_hs, s1_vs, s1_fs;
    logic [15:0] s1_x, s1_y;
    logic        pix_ok;
    logic        unused_msb;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 16'd0 : vc + 16'd1;
        end else begin
            hc <= hc + 16'd1;
        end
    end

    assign frame_wrap = (hc == H_LAST) && (vc == V_LAST);
    assign active     = (hc >= H_ACT_S) && (hc < H_ACT_E) && (vc >= V_ACT_S) && (vc < V_ACT_E);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Mode changes only at the frame wrap so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_wrap && iEnable) state_nxt = PRIME;
            PRIME:   if (frame_wrap) begin
                         if (!iEnable)        state_nxt = IDLE;
                         else if (!iRd_empty) state_nxt = RUN;
                     end
            RUN:     if (frame_wrap && !iEnable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign oRd_req = (state == RUN) && active;

    // Stage 1 covers the FIFO read latency; pixel data arrives during this stage.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_req <= 1'b0;
            s1_uf  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
            s1_fs  <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_req <= oRd_req;
            s1_uf  <= oRd_req && iRd_empty;
            s1_hs  <= !(hc < H_SYNC_E);
            s1_vs  <= !(vc < V_SYNC_E);
            s1_fs  <= oRd_req && (hc == H_ACT_S) && (vc == V_ACT_S);
            s1_x   <= oRd_req ? hc - H_ACT_S : 16'd0;
            s1_y   <= oRd_req ? vc - V_ACT_S : 16'd0;
        end
    end

    assign pix_ok     = s1_req && !s1_uf;
    assign unused_msb = iRd1_data[15] ^ iRd2_data[15];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oLCD_R      <= '0;
            oLCD_G      <= '0;
            oLCD_B      <= '0;
            oLCD_HS     <= 1'b1;
            oLCD_VS     <= 1'b1;
            oLCD_DE     <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrameStart <= 1'b0;
            oUnderflow  <= 1'b0;
        end else begin
            oLCD_R      <= pix_ok ? iRd2_data[9:0] : 10'd0;
            oLCD_G      <= pix_ok ? {iRd1_data[14:10], iRd2_data[14:10]} : 10'd0;
            oLCD_B      <= pix_ok ? iRd1_data[9:0] : 10'd0;
            oLCD_HS     <= s1_hs;
            oLCD_VS     <= s1_vs;
            oLCD_DE     <= s1_req;
            oX_Cont     <= s1_x;
            oY_Cont     <= s1_y;
            oFrameStart <= s1_fs;
            // A fresh underflow outranks a simultaneous clear.
            if (s1_uf)              oUnderflow <= 1'b1;
            else if (iClrUnderflow) oUnderflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader using a shrunken raster (15 x 11 clocks per frame).
module tb_lcd_frame_reader;

    localparam int HT  = 15;   // 2 sync + 3 bp + 8 active + 2 fp
    localparam int VT  = 11;   // 2 sync + 2 bp + 5 active + 2 fp
    localparam int FT  = HT * VT;
    localparam int HA0 = 5;
    localparam int VA0 = 4;

    logic        iClk, iRst_n, iEnable, iRd_empty, iClrUnderflow;
    logic [15:0] iRd1_data, iRd2_data;
    logic        oRd_req, oLCD_HS, oLCD_VS, oLCD_DE, oFrameStart, oUnderflow;
    logic [9:0]  oLCD_R, oLCD_G, oLCD_B;
    logic [15:0] oX_Cont, oY_Cont;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    lcd_frame_reader #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(2)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable),
        .iRd1_data(iRd1_data), .iRd2_data(iRd2_data), .iRd_empty(iRd_empty),
        .iClrUnderflow(iClrUnderflow), .oRd_req(oRd_req),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
        .oLCD_HS(oLCD_HS), .oLCD_VS(oLCD_VS), .oLCD_DE(oLCD_DE),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFrameStart(oFrameStart), .oUnderflow(oUnderflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Clocks since reset release; at a falling edge this equals the DUT's raster position.
    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic act(input int c);
        int h, v;
        h = c % HT;
        v = (c / HT) % VT;
        return (h >= HA0) && (h < HA0 + 8) && (v >= VA0) && (v < VA0 + 5);
    endfunction

    function automatic logic [15:0] w1(input int n);
        return {1'b1, 15'(n * 37 + 5)};
    endfunction

    function automatic logic [15:0] w2(input int n);
        return {1'b1, 15'(n * 91 + 3)};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge iClk);
    endtask

    task automatic test_reset();
        iRst_n = 1'b1; iEnable = 1'b1; iRd_empty = 1'b0; iClrUnderflow = 1'b0;
        iRd1_data = '0; iRd2_data = '0;
        #2 iRst_n = 1'b0;
        #1;
        n_checks++;
        if ({oRd_req, oLCD_DE, oFrameStart, oUnderflow} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ctl got=%b want=0000", {oRd_req, oLCD_DE, oFrameStart, oUnderflow});
        end
        n_checks++;
        if ({oLCD_HS, oLCD_VS} !== 2'b11) begin
            n_errors++; $display("FAIL reset_sync got=%b want=11", {oLCD_HS, oLCD_VS});
        end
        n_checks++;
        if ({oLCD_R, oLCD_G, oLCD_B} !== 30'd0 || oX_Cont !== 16'd0 || oY_Cont !== 16'd0) begin
            n_errors++; $display("FAIL reset_data rgb=%h x=%0d y=%0d want all 0", {oLCD_R, oLCD_G, oLCD_B}, oX_Cont, oY_Cont);
        end
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
    endtask

    // Three frames from release: IDLE, PRIME, then RUN with per-cycle varying FIFO words.
    task automatic test_scan_timing();
        int e_req, e_sync, e_de, e_xy, e_rgb, e_fs, first_req, hs_low, vs_low, nreq2, p;
        logic rq, de_e, hs_e, vs_e, fs_e;
        logic [15:0] a, b, x_e, y_e;
        logic [9:0] r_e, g_e, b_e;
        e_req = 0; e_sync = 0; e_de = 0; e_xy = 0; e_rgb = 0; e_fs = 0;
        first_req = -1; hs_low = 0; vs_low = 0; nreq2 = 0;
        for (int c = 0; c < 3 * FT; c++) begin
            rq = (c / FT >= 2) && act(c);
            if (oRd_req !== rq) e_req++;
            if (oRd_req === 1'b1 && first_req < 0) first_req = c;
            if (c >= 2 * FT && oRd_req === 1'b1) nreq2++;
            if (c < 2) begin
                de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0;
                x_e = '0; y_e = '0; r_e = '0; g_e = '0; b_e = '0;
            end else begin
                p = c - 2;
                de_e = (p / FT >= 2) && act(p);
                hs_e = (p % HT) >= 2;
                vs_e = ((p / HT) % VT) >= 2;
                fs_e = de_e && (p % HT == HA0) && ((p / HT) % VT == VA0);
                x_e  = de_e ? 16'(p % HT - HA0) : 16'd0;
                y_e  = de_e ? 16'((p / HT) % VT - VA0) : 16'd0;
                a = w1(p); b = w2(p);
                r_e = de_e ? b[9:0] : 10'd0;
                g_e = de_e ? {a[14:10], b[14:10]} : 10'd0;
                b_e = de_e ? a[9:0] : 10'd0;
            end
            if (oLCD_HS !== hs_e || oLCD_VS !== vs_e) e_sync++;
            if (oLCD_DE !== de_e) e_de++;
            if (oX_Cont !== x_e || oY_Cont !== y_e) e_xy++;
            if (oLCD_R !== r_e || oLCD_G !== g_e || oLCD_B !== b_e) e_rgb++;
            if (oFrameStart !== fs_e) e_fs++;
            if (c >= 2 && c < FT + 2) begin
                if (oLCD_HS === 1'b0) hs_low++;
                if (oLCD_VS === 1'b0) vs_low++;
            end
            iRd1_data = w1(c - 1);
            iRd2_data = w2(c - 1);
            @(negedge iClk);
        end
        n_checks++; if (e_req != 0)  begin n_errors++; $display("FAIL scan_req bad_cycles=%0d want=0", e_req); end
        n_checks++; if (e_sync != 0) begin n_errors++; $display("FAIL scan_sync bad_cycles=%0d want=0", e_sync); end
        n_checks++; if (e_de != 0)   begin n_errors++; $display("FAIL scan_de bad_cycles=%0d want=0", e_de); end
        n_checks++; if (e_xy != 0)   begin n_errors++; $display("FAIL scan_xy bad_cycles=%0d want=0", e_xy); end
        n_checks++; if (e_rgb != 0)  begin n_errors++; $display("FAIL scan_rgb bad_cycles=%0d want=0", e_rgb); end
        n_checks++; if (e_fs != 0)   begin n_errors++; $display("FAIL scan_framestart bad_cycles=%0d want=0", e_fs); end
        n_checks++; if (first_req != 395) begin n_errors++; $display("FAIL first_req cycle=%0d want=395", first_req); end
        n_checks++; if (hs_low != 22) begin n_errors++; $display("FAIL hs_low_per_frame got=%0d want=22", hs_low); end
        n_checks++; if (vs_low != 30) begin n_errors++; $display("FAIL vs_low_per_frame got=%0d want=30", vs_low); end
        n_checks++; if (nreq2 != 40)  begin n_errors++; $display("FAIL reqs_frame2 got=%0d want=40", nreq2); end
    endtask

    task automatic test_unpack();
        int req_at, de_at;
        req_at = -1; de_at = -1;
        iRd1_data = 16'h7FFF;
        iRd2_data = 16'h0155;
        for (int i = 0; i < 200 && de_at < 0; i++) begin
            if (oRd_req === 1'b1 && req_at < 0) req_at = cyc;
            if (oLCD_DE === 1'b1) de_at = cyc;
            else @(negedge iClk);
        end
        n_checks++; if (req_at != 560) begin n_errors++; $display("FAIL unpack_req_cycle got=%0d want=560", req_at); end
        n_checks++; if (de_at != 562)  begin n_errors++; $display("FAIL unpack_de_cycle got=%0d want=562", de_at); end
        n_checks++;
        if (oLCD_R !== 10'h155 || oLCD_G !== 10'h3E0 || oLCD_B !== 10'h3FF) begin
            n_errors++; $display("FAIL unpack_rgb got=%h/%h/%h want=155/3e0/3ff", oLCD_R, oLCD_G, oLCD_B);
        end
        n_checks++;
        if (oFrameStart !== 1'b1 || oX_Cont !== 16'd0 || oY_Cont !== 16'd0) begin
            n_errors++; $display("FAIL unpack_first_pixel fs=%b x=%0d y=%0d want 1/0/0", oFrameStart, oX_Cont, oY_Cont);
        end
        @(negedge iClk);
        n_checks++;
        if (oFrameStart !== 1'b0 || oX_Cont !== 16'd1) begin
            n_errors++; $display("FAIL unpack_second_pixel fs=%b x=%0d want 0/1", oFrameStart, oX_Cont);
        end
    endtask

    // Empty FIFO for the requests at hc 5..9 of row vc=5 in frame 3.
    task automatic test_underflow();
        wait_cyc(575);
        for (int i = 0; i <= 10; i++) begin
            if (i == 1) begin
                n_checks++;
                if (oUnderflow !== 1'b0) begin n_errors++; $display("FAIL uf_early got=%b want=0", oUnderflow); end
            end
            if (i >= 2 && i <= 6) begin
                n_checks++;
                if ({oLCD_DE, oLCD_R, oLCD_G, oLCD_B, oUnderflow} !== {1'b1, 30'd0, 1'b1}) begin
                    n_errors++;
                    $display("FAIL uf_black_%0d de=%b rgb=%h uf=%b want de=1 rgb=0 uf=1", i, oLCD_DE, {oLCD_R, oLCD_G, oLCD_B}, oUnderflow);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (oLCD_DE !== 1'b1 || oLCD_R !== 10'h155 || oUnderflow !== 1'b1) begin
                    n_errors++; $display("FAIL uf_recover de=%b r=%h uf=%b want 1/155/1", oLCD_DE, oLCD_R, oUnderflow);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (oUnderflow !== 1'b1) begin n_errors++; $display("FAIL uf_sticky got=%b want=1", oUnderflow); end
            end
            if (i == 10) begin
                n_checks++;
                if (oUnderflow !== 1'b0) begin n_errors++; $display("FAIL uf_clear got=%b want=0", oUnderflow); end
            end
            iRd_empty     = (i < 5);
            iClrUnderflow = (i == 3 || i == 9);
            @(negedge iClk);
        end
        iRd_empty = 1'b0;
        iClrUnderflow = 1'b0;
    endtask

    // Enable dropped mid-frame 4: frame completes, frame 5 is idle; re-enabled late in frame 5.
    task automatic test_enable_drop();
        int n4, n5, de4, de5;
        n4 = 0; n5 = 0; de4 = 0; de5 = 0;
        wait_cyc(4 * FT);
        for (int c = 4 * FT; c < 6 * FT; c++) begin
            if (oRd_req === 1'b1) begin
                if (c < 5 * FT) n4++; else n5++;
            end
            if (oLCD_DE === 1'b1) begin
                if (c < 5 * FT + 2) de4++; else de5++;
            end
            if (c == 4 * FT + 6 * HT) iEnable = 1'b0;
            if (c == 900) iEnable = 1'b1;
            @(negedge iClk);
        end
        n_checks++; if (n4 != 40)  begin n_errors++; $display("FAIL drop_reqs_frame got=%0d want=40", n4); end
        n_checks++; if (de4 != 40) begin n_errors++; $display("FAIL drop_de_frame got=%0d want=40", de4); end
        n_checks++; if (n5 != 0)   begin n_errors++; $display("FAIL drop_reqs_after got=%0d want=0", n5); end
        n_checks++; if (de5 != 0)  begin n_errors++; $display("FAIL drop_de_after got=%0d want=0", de5); end
    endtask

    // Frame 7 is RUN again; reset lands between clock edges at hc=8, vc=6.
    task automatic test_async_reset();
        int first;
        wait_cyc(7 * FT + 6 * HT + 8);
        n_checks++;
        if (oRd_req !== 1'b1 || oLCD_DE !== 1'b1 || oX_Cont !== 16'd1) begin
            n_errors++; $display("FAIL pre_reset req=%b de=%b x=%0d want 1/1/1", oRd_req, oLCD_DE, oX_Cont);
        end
        #2 iRst_n = 1'b0;
        #1;
        n_checks++;
        if ({oRd_req, oLCD_DE, oFrameStart, oUnderflow, oLCD_HS, oLCD_VS} !== 6'b000011) begin
            n_errors++;
            $display("FAIL async_reset_ctl got=%b want=000011", {oRd_req, oLCD_DE, oFrameStart, oUnderflow, oLCD_HS, oLCD_VS});
        end
        n_checks++;
        if ({oLCD_R, oLCD_G, oLCD_B} !== 30'd0 || oX_Cont !== 16'd0 || oY_Cont !== 16'd0) begin
            n_errors++; $display("FAIL async_reset_data rgb=%h x=%0d y=%0d want 0", {oLCD_R, oLCD_G, oLCD_B}, oX_Cont, oY_Cont);
        end
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 600 && first < 0; i++) begin
            if (oRd_req === 1'b1) first = cyc;
            else @(negedge iClk);
        end
        n_checks++;
        if (first != 395) begin n_errors++; $display("FAIL restart_first_req cycle=%0d want=395", first); end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_unpack();
        test_underflow();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_frame_reader.md
LCD_FRAME_READER -- requirements
Module: lcd_frame_reader

Interface
REQ-001 Parameters (name, default, meaning):
- H_SYNC 30: HS pulse width, clocks
- H_BP 46: horizontal back porch
- H_ACTIVE 800: visible pixels per line
- H_FP 16: horizontal front porch
- V_SYNC 3: VS pulse width, lines
- V_BP 23: vertical back porch
- V_ACTIVE 480: visible lines
- V_FP 7: vertical front porch
REQ-002 Ports (name, direction, width, meaning):
- iClk in 1: sole clock; every register on its rising edge
- iRst_n in 1: asynchronous active-low reset
- iEnable in 1: scan-out enable, level
- iRd1_data in 16: frame-buffer word 1, {x, G[11:7], B[11:2]}
- iRd2_data in 16: frame-buffer word 2, {x, G[6:2], R[11:2]}
- iRd_empty in 1: read FIFO empty
- iClrUnderflow in 1: clears oUnderflow
- oRd_req out 1: read strobe to both FIFOs
- oLCD_R out 10: red pixel
- oLCD_G out 10: green pixel
- oLCD_B out 10: blue pixel
- oLCD_HS out 1: horizontal sync, active low
- oLCD_VS out 1: vertical sync, active low
- oLCD_DE out 1: data enable
- oX_Cont out 16: active-pixel column
- oY_Cont out 16: active-pixel row
- oFrameStart out 1: one-cycle pulse marking first active pixel of a frame
- oUnderflow out 1: sticky underflow flag

Function
REQ-003 Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) SHALL run continuously, H_TOTAL=892, V_TOTAL=513; vc increments when hc wraps; vc wraps to 0 after V_TOTAL-1.
REQ-004 Each line and frame SHALL be ordered sync, back porch, active, front porch, with hc=0 / vc=0 at sync start; active = hc in [76,876) and vc in [26,506).
REQ-005 FSM states SHALL be IDLE, PRIME and RUN; reset state is IDLE.
REQ-006 IDLE->PRIME SHALL occur when iEnable=1 at hc=H_TOTAL-1, vc=V_TOTAL-1.
REQ-007 PRIME->RUN SHALL occur at the same frame-wrap point when iRd_empty=0; otherwise the FSM stays in PRIME.
REQ-008 RUN->IDLE SHALL occur at the frame-wrap point when iEnable=0; deasserting iEnable mid-frame never truncates a frame.
REQ-009 oRd_req SHALL be 1 in exactly those cycles where state=RUN and (hc,vc) is active (combinational from registered state); it is 0 in IDLE and PRIME.
REQ-010 FIFO data SHALL be sampled the cycle after oRd_req (one-cycle read latency), and all LCD outputs SHALL appear two cycles after the corresponding counter value.
- Applies to HS, VS, DE, RGB, X, Y and oFrameStart.
- HS and VS toggle in IDLE and PRIME as well.
- DE and RGB are 0 outside RUN.
REQ-011 Unpacking SHALL be: R=iRd2_data[9:0], B=iRd1_data[9:0], G={iRd1_data[14:10], iRd2_data[14:10]}; bit 15 of both words is ignored.
REQ-012 If oRd_req=1 while iRd_empty=1, the pixel SHALL be output as R=G=B=0, DE SHALL still assert, and oUnderflow SHALL set to 1 two cycles later, aligned with that pixel.
REQ-013 oUnderflow SHALL clear on iClrUnderflow=1; if clear and a new underflow coincide, set wins.
REQ-014 oX_Cont = hc-76 and oY_Cont = vc-26 for active pixels (delayed per REQ-010); both SHALL be 0 when DE=0.
REQ-015 oFrameStart SHALL pulse with the first DE of each frame in RUN only.

Reset
REQ-016 On iRst_n=0, immediately and asynchronously:
- state=IDLE, hc=vc=0
- oRd_req=0, RGB=0, DE=0, oFrameStart=0, oUnderflow=0, X=Y=0
- HS=1, VS=1
REQ-017 Reset asserted mid-frame SHALL abort scan-out; after release, counting restarts at hc=vc=0 and the FSM reaches RUN no earlier than the next frame wrap.

Verification
REQ-018 Reset release with iEnable=1 and FIFO non-empty -> first oRd_req at the first active pixel of frame 2 (hc=76, vc=26); HS low for 30 clocks per 892; VS low for 3 lines per 513.
REQ-019 Words rd1=16'h7FFF, rd2=16'h0155 -> R=10'h155, G=10'h3E0, B=10'h3FF, with DE two cycles after the request.
REQ-020 iRd_empty forced high for 5 active cycles in RUN -> 5 black pixels with DE=1, oUnderflow=1 until iClrUnderflow; clear pulsed on an underflow cycle leaves oUnderflow=1.
REQ-021 iEnable dropped at vc=200 -> frame completes with 384000 requests total, then IDLE, DE=0, no further oRd_req.
REQ-022 iRst_n pulsed low at hc=400, vc=300 -> outputs go to reset values without waiting for a clock edge; no oRd_req until the next frame wrap after release.
